// File: rtl/wb_xbar_dec.sv
// wb_xbar_dec: Wishbone classic single-master to NUM_SLAVES decoder/bridge.
// Each master request is registered, decoded against a mask/base map,
// forwarded to exactly one slave, and answered one cycle after the slave
// responds. Unmapped accesses and hung slaves are terminated with err.

// Address match for one slave region.
module wb_xbar_dec_hit #(
  parameter int AW = 32
) (
  input  logic [AW-1:0] i_adr,
  input  logic [AW-1:0] i_base,
  input  logic [AW-1:0] i_mask,
  output logic          o_hit
);
  assign o_hit = ((i_adr ^ i_base) & i_mask) == '0;
endmodule

module wb_xbar_dec #(
  parameter int                       NUM_SLAVES = 5,
  parameter int                       AW         = 32,
  parameter int                       DW         = 32,
  parameter logic [NUM_SLAVES*AW-1:0] SLV_BASE   = '0,
  parameter logic [NUM_SLAVES*AW-1:0] SLV_MASK   = '0,
  parameter int                       TIMEOUT    = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [AW-1:0]            wbm_adr_i,
  input  logic [DW-1:0]            wbm_dat_i,
  input  logic [DW/8-1:0]          wbm_sel_i,
  input  logic                     wbm_we_i,
  input  logic                     wbm_cyc_i,
  input  logic                     wbm_stb_i,
  output logic [DW-1:0]            wbm_dat_o,
  output logic                     wbm_ack_o,
  output logic                     wbm_err_o,
  output logic [AW-1:0]            wbs_adr_o,
  output logic [DW-1:0]            wbs_dat_o,
  output logic [DW/8-1:0]          wbs_sel_o,
  output logic                     wbs_we_o,
  output logic [NUM_SLAVES-1:0]    wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]    wbs_stb_o,
  input  logic [NUM_SLAVES*DW-1:0] wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]    wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]    wbs_err_i,
  output logic                     timeout_o
);

  // Counter needs at least one bit even when the timeout is disabled.
  localparam int            CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW:0]   TO_LIM = (CW + 1)'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  state_t                r_state;
  logic [NUM_SLAVES-1:0] r_cyc;   // one-hot selected slave, drives cyc and stb
  logic [CW-1:0]         r_cnt;

  logic [NUM_SLAVES-1:0] w_hit;
  logic [NUM_SLAVES-1:0] w_sel;
  logic                  w_s_ack;
  logic                  w_s_err;
  logic                  w_to;
  logic [DW-1:0]         w_rdat;

  genvar k;
  generate
    for (k = 0; k < NUM_SLAVES; k++) begin : g_hit
      wb_xbar_dec_hit #(.AW(AW)) u_hit (
        .i_adr  (wbm_adr_i),
        .i_base (SLV_BASE[k*AW +: AW]),
        .i_mask (SLV_MASK[k*AW +: AW]),
        .o_hit  (w_hit[k])
      );
    end
  endgenerate

  // Lowest set bit of the hit vector: lowest index wins on overlap.
  assign w_sel = w_hit & (~w_hit + NUM_SLAVES'(1));

  // Only the selected slave's response lines are observed.
  assign w_s_ack = |(wbs_ack_i & r_cyc);
  assign w_s_err = |(wbs_err_i & r_cyc);

  // Timeout fires on the cycle the count would reach TIMEOUT.
  assign w_to = (TIMEOUT != 0) && (({1'b0, r_cnt} + 1'b1) >= TO_LIM);

  assign wbs_cyc_o = r_cyc;
  assign wbs_stb_o = r_cyc;

  // Read data mux driven by the one-hot selection.
  always_comb begin
    w_rdat = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (r_cyc[i]) w_rdat = w_rdat | wbs_dat_i[i*DW +: DW];
  end

  // Transaction FSM: decode in IDLE, wait for slave in ACTIVE, answer in RESP.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= IDLE;
      r_cyc     <= '0;
      r_cnt     <= '0;
      wbs_adr_o <= '0;
      wbs_dat_o <= '0;
      wbs_sel_o <= '0;
      wbs_we_o  <= 1'b0;
      wbm_dat_o <= '0;
      wbm_ack_o <= 1'b0;
      wbm_err_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      wbm_ack_o <= 1'b0;
      wbm_err_o <= 1'b0;
      timeout_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (wbm_cyc_i && wbm_stb_i) begin
            wbs_adr_o <= wbm_adr_i;
            wbs_dat_o <= wbm_dat_i;
            wbs_sel_o <= wbm_sel_i;
            wbs_we_o  <= wbm_we_i;
            r_cnt     <= '0;
            if (|w_hit) begin
              r_cyc   <= w_sel;
              r_state <= ACTIVE;
            end else begin
              // Unmapped: answer with err straight away, no slave strobe.
              wbm_err_o <= 1'b1;
              wbm_dat_o <= '0;
              r_state   <= RESP;
            end
          end
        end
        ACTIVE: begin
          if (!wbm_cyc_i) begin
            // Master abandoned the cycle: release the slave silently.
            r_cyc   <= '0;
            r_state <= IDLE;
          end else if (w_s_ack || w_s_err) begin
            r_cyc     <= '0;
            wbm_ack_o <= ~w_s_err;
            wbm_err_o <= w_s_err;
            wbm_dat_o <= wbs_we_o ? '0 : w_rdat;
            r_state   <= RESP;
          end else if (w_to) begin
            r_cyc     <= '0;
            timeout_o <= 1'b1;
            wbm_err_o <= 1'b1;
            wbm_dat_o <= '0;
            r_state   <= RESP;
          end else begin
            r_cnt <= (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
          end
        end
        RESP: begin
          // ack/err are up for this single cycle; the default clears them.
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
